// File: rtl/handshake_pkg.sv
// Shared definitions for the ready/valid fork transmitter and its slots.
package handshake_pkg;

    // Default geometry of the fork.
    localparam int HS_WIDTH = 4;
    localparam int HS_N_OUT = 3;
    localparam int HS_CNT_W = 8;

    // Word and per-channel mask types at the default geometry.
    typedef logic [HS_WIDTH-1:0] hs_word_t;
    typedef logic [HS_N_OUT-1:0] hs_mask_t;

    // Holding-register action chosen for one clock edge.
    typedef enum logic [1:0] {
        HS_HOLD  = 2'd0,
        HS_LOAD  = 2'd1,
        HS_DRAIN = 2'd2
    } hs_action_e;

    // Pick the holding-register action from the accept/complete pair.
    // A new accept always wins: it both retires the old word (if any)
    // and loads the new one at the same edge.
    function automatic hs_action_e hs_action(input logic load, input logic complete);
        hs_action_e act;
        if (load) begin
            act = HS_LOAD;
        end else if (complete) begin
            act = HS_DRAIN;
        end else begin
            act = HS_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/handshake_fork_slot.sv
// One downstream channel of the eager fork: tracks whether this channel
// has already taken the current word and masks its valid accordingly.
module handshake_fork_slot
    import handshake_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic full,
    input  logic complete,
    input  logic load,
    input  logic o_ready,
    output logic o_valid,
    output logic done_or_fire
);

    logic done_q;
    logic done_d;
    logic fire_s;
    hs_action_e act_s;

    // Valid is raised only while a word is held and this channel has not
    // yet consumed it, so a channel never sees the same word twice.
    always_comb begin
        o_valid      = full & ~done_q;
        fire_s       = o_valid & o_ready;
        done_or_fire = done_q | fire_s;
    end

    // Next value of the done bit: cleared on a new word or on retirement,
    // otherwise accumulates this channel's fire while a word is held.
    always_comb begin
        done_d = done_q;
        act_s  = hs_action(load, complete);
        case (act_s)
            HS_LOAD:  done_d = 1'b0;
            HS_DRAIN: done_d = 1'b0;
            HS_HOLD: begin
                if (full) begin
                    done_d = done_q | fire_s;
                end else begin
                    done_d = done_q;
                end
            end
            default:  done_d = 1'b0;
        endcase
    end

    // Done-bit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/handshake_fork_tx.sv
// Eager ready/valid fork: registers one upstream word and broadcasts it to
// N_OUT channels; the word retires once every channel has taken it, and a
// wrapping counter records each retirement.
module handshake_fork_tx
    import handshake_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int N_OUT = HS_N_OUT,
    parameter int CNT_W = HS_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic [WIDTH-1:0] I_data,
    output logic [N_OUT-1:0] O_valid,
    input  logic [N_OUT-1:0] O_ready,
    output logic [WIDTH-1:0] O_data,
    output logic [CNT_W-1:0] retired
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [N_OUT-1:0] done_or_fire_s;
    logic             complete_s;
    logic             load_s;
    hs_action_e       act_s;

    // Per-channel slots, each holding its own done bit.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_slot
            handshake_fork_slot u_slot (
                .clk          (CLK),
                .reset        (RESET),
                .full         (full_q),
                .complete     (complete_s),
                .load         (load_s),
                .o_ready      (O_ready[gi]),
                .o_valid      (O_valid[gi]),
                .done_or_fire (done_or_fire_s[gi])
            );
        end
    endgenerate

    // Retirement and upstream handshake: the held word completes when every
    // channel has either fired earlier or fires now, which frees the
    // register in the same cycle so streaming runs at one word per cycle.
    always_comb begin
        complete_s = full_q & (&done_or_fire_s);
        I_ready    = ~RESET & (~full_q | complete_s);
        load_s     = I_valid & I_ready;
        O_data     = data_q;
        retired    = cnt_q;
    end

    // Next state of the holding register and the retirement counter.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        act_s  = hs_action(load_s, complete_s);
        case (act_s)
            HS_LOAD: begin
                full_d = 1'b1;
                data_d = I_data;
            end
            HS_DRAIN: begin
                full_d = 1'b0;
                data_d = data_q;
            end
            HS_HOLD: begin
                full_d = full_q;
                data_d = data_q;
            end
            default: begin
                full_d = 1'b0;
                data_d = data_q;
            end
        endcase

        if (complete_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset; reset drops any pending word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            full_q <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_handshake_fork_tx.sv
// Directed bench for handshake_fork_tx at the default geometry.
module tb_handshake_fork_tx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       I_valid;
    logic       I_ready;
    logic [3:0] I_data;
    logic [2:0] O_valid;
    logic [2:0] O_ready;
    logic [3:0] O_data;
    logic [7:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    handshake_fork_tx #(.WIDTH(4), .N_OUT(3), .CNT_W(8)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I_valid (I_valid),
        .I_ready (I_ready),
        .I_data  (I_data),
        .O_valid (O_valid),
        .O_ready (O_ready),
        .O_data  (O_data),
        .retired (retired)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset ----------------
        RESET   = 1'b1;
        I_valid = 1'b1;
        I_data  = 4'hA;
        O_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_iready", {31'd0, I_ready}, 32'd0);
            chk("rst_ovalid", {29'd0, O_valid}, 32'd0);
        end
        RESET   = 1'b0;
        I_valid = 1'b0;
        #1;
        chk("rst_retired", {24'd0, retired}, 32'd0);
        chk("rst_odata", {28'd0, O_data}, 32'd0);
        chk("post_rst_iready", {31'd0, I_ready}, 32'd1);

        // ---------------- streaming ----------------
        O_ready = 3'b111;
        for (int i = 1; i <= 4; i++) begin
            I_valid = 1'b1;
            I_data  = 4'(i);
            #1;
            chk("stream_iready", {31'd0, I_ready}, 32'd1);
            if (i > 1) begin
                chk("stream_odata", {28'd0, O_data}, 32'(i - 1));
                chk("stream_ovalid", {29'd0, O_valid}, 32'h7);
                chk("stream_retired", {24'd0, retired}, 32'(i - 2));
            end
            tick();
        end
        I_valid = 1'b0;
        #1;
        chk("stream_last_odata", {28'd0, O_data}, 32'd4);
        chk("stream_last_ovalid", {29'd0, O_valid}, 32'h7);
        chk("stream_last_retired", {24'd0, retired}, 32'd3);
        tick();
        chk("stream_retired4", {24'd0, retired}, 32'd4);
        chk("stream_idle_ovalid", {29'd0, O_valid}, 32'd0);

        // ---------------- staggered accept ----------------
        O_ready = 3'b000;
        I_valid = 1'b1;
        I_data  = 4'h5;
        tick();
        I_valid = 1'b0;
        O_ready = 3'b001;
        #1;
        chk("stag_ovalid0", {29'd0, O_valid}, 32'h7);
        chk("stag_odata", {28'd0, O_data}, 32'h5);
        chk("stag_iready0", {31'd0, I_ready}, 32'd0);
        tick();
        O_ready = 3'b010;
        #1;
        chk("stag_ovalid1", {29'd0, O_valid}, 32'h6);
        chk("stag_iready1", {31'd0, I_ready}, 32'd0);
        tick();
        O_ready = 3'b100;
        #1;
        chk("stag_ovalid2", {29'd0, O_valid}, 32'h4);
        chk("stag_iready2", {31'd0, I_ready}, 32'd1);
        chk("stag_retired_before", {24'd0, retired}, 32'd4);
        tick();
        O_ready = 3'b000;
        #1;
        chk("stag_ovalid3", {29'd0, O_valid}, 32'h0);
        chk("stag_retired", {24'd0, retired}, 32'd5);

        // ---------------- backpressure hold ----------------
        I_valid = 1'b1;
        I_data  = 4'h6;
        tick();
        for (int k = 0; k < 10; k++) begin
            I_data = 4'(7 + k);
            #1;
            chk("bp_odata", {28'd0, O_data}, 32'h6);
            chk("bp_ovalid", {29'd0, O_valid}, 32'h7);
            chk("bp_iready", {31'd0, I_ready}, 32'd0);
            chk("bp_retired", {24'd0, retired}, 32'd5);
            tick();
        end
        I_valid = 1'b0;
        O_ready = 3'b111;
        #1;
        chk("bp_drain_iready", {31'd0, I_ready}, 32'd1);
        tick();
        O_ready = 3'b000;
        #1;
        chk("bp_drain_retired", {24'd0, retired}, 32'd6);
        chk("bp_drain_ovalid", {29'd0, O_valid}, 32'd0);

        // ---------------- reset mid-transfer ----------------
        I_valid = 1'b1;
        I_data  = 4'h9;
        tick();
        I_valid = 1'b0;
        O_ready = 3'b001;
        #1;
        chk("mid_ovalid0", {29'd0, O_valid}, 32'h7);
        tick();
        O_ready = 3'b000;
        #1;
        chk("mid_ovalid1", {29'd0, O_valid}, 32'h6);
        RESET = 1'b1;
        #1;
        chk("mid_rst_iready", {31'd0, I_ready}, 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        chk("mid_post_ovalid", {29'd0, O_valid}, 32'd0);
        chk("mid_post_retired", {24'd0, retired}, 32'd0);
        chk("mid_post_odata", {28'd0, O_data}, 32'd0);
        I_valid = 1'b1;
        I_data  = 4'h3;
        tick();
        I_valid = 1'b0;
        O_ready = 3'b111;
        #1;
        chk("mid_new_ovalid", {29'd0, O_valid}, 32'h7);
        chk("mid_new_odata", {28'd0, O_data}, 32'h3);
        tick();
        O_ready = 3'b000;
        #1;
        chk("mid_new_retired", {24'd0, retired}, 32'd1);
        chk("mid_new_idle", {29'd0, O_valid}, 32'd0);

        // ---------------- counter wrap ----------------
        // One retirement already counted; 255 more bring the total to 256.
        O_ready = 3'b111;
        I_valid = 1'b1;
        for (int k = 0; k < 255; k++) begin
            I_data = 4'(k);
            tick();
        end
        I_valid = 1'b0;
        #1;
        chk("wrap_pre", {24'd0, retired}, 32'hFF);
        chk("wrap_pre_odata", {28'd0, O_data}, 32'hE);
        tick();
        chk("wrap_zero", {24'd0, retired}, 32'h00);
        I_valid = 1'b1;
        I_data  = 4'h1;
        tick();
        I_valid = 1'b0;
        tick();
        chk("wrap_one", {24'd0, retired}, 32'h01);
        chk("wrap_idle", {29'd0, O_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
